decryption_controller: RTL
==========================

DECRYPTION_CONTROLLER -- requirements
Module: decryption_controller

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  synchronous active-low reset.
REQ-004 start  input  1  request to decrypt in_data; sampled only in IDLE.
REQ-005 in_data  input  128  ciphertext block, captured when start is accepted.
REQ-006 ark_out  input  128  AddRoundKey result of process_in_data with round key round_key_idx.
REQ-007 isb_out  input  128  InvSubBytes result of process_in_data.
REQ-008 imc_out  input  128  InvMixColumns result of process_in_data.
REQ-009 isr_out  input  128  InvShiftRows result of process_in_data.
REQ-010 process_in_data  output  128  registered working state, fed to all four stage units.
REQ-011 process_output  output  2  stage select: 00 ARK, 01 ISB, 10 IMC, 11 ISR.
REQ-012 round_key_idx  output  4  round key index for the external key store, 0..10.
REQ-013 busy  output  1  high while a block is in flight.
REQ-014 done  output  1  one-cycle pulse when out_data is valid.
REQ-015 out_data  output  128  plaintext result; holds until the next done.

Function
REQ-016 States SHALL be IDLE, ARK, ISR, ISB, IMC and DONE; the state, process_in_data, round_key_idx and out_data SHALL be registered.
REQ-017 Each stage state SHALL last exactly one cycle, drive process_output with its own code, and write the selected stage input into process_in_data at the end of the cycle.
REQ-018 IDLE with start=1: process_in_data <= in_data, round_key_idx <= 10, next state ARK; with start=0 the block SHALL stay in IDLE.
REQ-019 ARK with idx=10: idx <= 9, next state ISR.
REQ-020 ARK with idx 1..9: next state IMC, idx unchanged.
REQ-021 ARK with idx=0: out_data <= ark_out, next state DONE.
REQ-022 ISR SHALL go to ISB; ISB SHALL go to ARK; IMC SHALL set idx <= idx-1 and go to ISR.
REQ-023 DONE SHALL assert done for one cycle and return to IDLE; process_in_data is unchanged in DONE.
REQ-024 busy SHALL be 1 in ARK, ISR, ISB and IMC, and 0 in IDLE and DONE.
REQ-025 Latency: start accepted at edge E0; ARK(10) is the cycle after E0; final ARK(0) is the 40th busy cycle; done is high in the 41st cycle after E0.
REQ-026 start asserted while busy or in DONE SHALL be ignored; there is no queueing.
REQ-027 process_output SHALL be 00 in IDLE and DONE.
REQ-028 round_key_idx SHALL never decrement below 0 or exceed 10; there is no wrap-around.
REQ-029 Full stage sequence per block: ARK10, then (ISR, ISB, ARK, IMC) for idx 9..1, then ISR, ISB, ARK0.

Reset
REQ-030 n_rst=0 at a rising edge SHALL force IDLE with process_output=00, round_key_idx=0, busy=0, done=0, process_in_data=0 and out_data=0.
REQ-031 Reset mid-operation SHALL abort the block with no done pulse; start is accepted on the first edge after n_rst returns high.

Verification
REQ-032 Reset: hold n_rst=0 for 2 cycles with start=1 -> all outputs 0, busy=0, and no start accepted.
REQ-033 Stubbed stages (ark_out=state^1, isb_out=state+2, imc_out=state+3, isr_out=state+4), in_data=0, pulse start -> process_output sequence 00,11,01,00,10,... as in REQ-029, idx 10,9,9,9,9,8,...,0, done exactly 41 cycles after the start edge.
REQ-034 Real AES stage units with key 000102030405060708090a0b0c0d0e0f and in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff on done.
REQ-035 start pulsed at busy cycles 5 and 40, and during DONE -> ignored; exactly one done pulse, and out_data unchanged by the extra pulses.
REQ-036 n_rst=0 during busy cycle 20 -> IDLE next cycle with no done; a new start then completes in 41 cycles with the correct result.
REQ-037 Back-to-back: start held high continuously -> a new block is accepted in each IDLE cycle, giving one done every 42 cycles.

Source files
------------

// File: rtl/decryption_controller.sv
// AES-128 inverse-cipher sequencer: steps one block through ARK/ISR/ISB/IMC
// using external stage units, one stage per cycle, rounds 10 down to 0.
//
// state | meaning
// IDLE  | waiting for start; captures in_data and loads round key index 10
// ARK   | AddRoundKey with key round_key_idx; idx 10 -> ISR, 1..9 -> IMC, 0 -> DONE
// ISR   | InvShiftRows
// ISB   | InvSubBytes
// IMC   | InvMixColumns; advances to the next lower round key
// DONE  | one-cycle done pulse, out_data valid
module decryption_controller (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] in_data,
  input  logic [127:0] ark_out,
  input  logic [127:0] isb_out,
  input  logic [127:0] imc_out,
  input  logic [127:0] isr_out,
  output logic [127:0] process_in_data,
  output logic [1:0]   process_output,
  output logic [3:0]   round_key_idx,
  output logic         busy,
  output logic         done,
  output logic [127:0] out_data
);

  typedef enum logic [2:0] {
    IDLE,
    ARK,
    ISR,
    ISB,
    IMC,
    DONE
  } state_t;

  localparam logic [1:0] SEL_ARK = 2'b00;
  localparam logic [1:0] SEL_ISB = 2'b01;
  localparam logic [1:0] SEL_IMC = 2'b10;
  localparam logic [1:0] SEL_ISR = 2'b11;

  state_t       state_q, state_d;
  logic [127:0] pid_d;
  logic [127:0] out_d;
  logic [3:0]   idx_d;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      process_in_data <= '0;
      round_key_idx   <= '0;
      out_data        <= '0;
    end else begin
      state_q         <= state_d;
      process_in_data <= pid_d;
      round_key_idx   <= idx_d;
      out_data        <= out_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pid_d          = process_in_data;
    idx_d          = round_key_idx;
    out_d          = out_data;
    process_output = SEL_ARK;
    busy           = 1'b0;
    done           = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pid_d   = in_data;
          idx_d   = 4'd10;
          state_d = ARK;
        end
      end
      ARK: begin
        busy           = 1'b1;
        process_output = SEL_ARK;
        pid_d          = ark_out;
        if (round_key_idx == 4'd10) begin
          idx_d   = 4'd9;
          state_d = ISR;
        end else if (round_key_idx == 4'd0) begin
          out_d   = ark_out;
          state_d = DONE;
        end else begin
          state_d = IMC;
        end
      end
      ISR: begin
        busy           = 1'b1;
        process_output = SEL_ISR;
        pid_d          = isr_out;
        state_d        = ISB;
      end
      ISB: begin
        busy           = 1'b1;
        process_output = SEL_ISB;
        pid_d          = isb_out;
        state_d        = ARK;
      end
      IMC: begin
        busy           = 1'b1;
        process_output = SEL_IMC;
        pid_d          = imc_out;
        // ARK never sends idx 0 here, so this guard only protects against underflow
        if (round_key_idx != 4'd0) idx_d = round_key_idx - 4'd1;
        state_d        = ISR;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
